aurora_tx_router_framer: RTL

//  Transmit-side framer for the router controller: the counterpart of the Aurora RX

---
 rtl/router_pkg.sv | 38 +++
 rtl/axis_out_reg.sv | 44 ++++
 rtl/aurora_tx_router_framer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: widths, header field offsets, FSM states.
// Used by the TX framer and by the RX address/data separator.
package router_pkg;

    localparam int          ADDR_W    = 10;
    localparam int          DATA_W    = 64;
    localparam logic [15:0] MAGIC     = 16'hBBBC;

    localparam int SRC_LSB   = 0;
    localparam int DST_LSB   = 10;
    localparam int LEN_LSB   = 20;
    localparam int MAGIC_LSB = 48;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_CSUM,
        ST_DONE
    } tx_state_e;

    // Header: {magic, 20'h0, len, dst, src}
    function automatic logic [63:0] build_hdr(
        input logic [15:0] magic,
        input logic [7:0]  len,
        input logic [9:0]  dst,
        input logic [9:0]  src
    );
        logic [63:0] h;
        h = '0;
        h[MAGIC_LSB +: 16] = magic;
        h[LEN_LSB   +: 8]  = len;
        h[DST_LSB   +: 10] = dst;
        h[SRC_LSB   +: 10] = src;
        return h;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI-Stream output register owning tdata/tvalid/tlast.
// Ports: load_i/din_i/last_i write a word; tready_i drains; can_load_o = !tvalid || tready.
module axis_out_reg
    import router_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] din_i,
    input  logic         last_i,
    input  logic         tready_i,
    output logic [W-1:0] tdata_o,
    output logic         tvalid_o,
    output logic         tlast_o,
    output logic         can_load_o
);

    logic [W-1:0] data_q;
    logic         valid_q;
    logic         last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (load_i) begin
            data_q  <= din_i;
            valid_q <= 1'b1;
            last_q  <= last_i;
        end else if (tready_i) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end
    end

    assign tdata_o    = data_q;
    assign tvalid_o   = valid_q;
    assign tlast_o    = last_q;
    assign can_load_o = !valid_q || tready_i;

endmodule

// File: rtl/aurora_tx_router_framer.sv
// TX framer: header, PAYLOAD_WORDS payload words, XOR checksum onto Aurora TX.
// Ports: router_* request side, pl_* payload source, aurora_tx_* AXI-Stream out.
module aurora_tx_router_framer
    import router_pkg::*;
#(
    parameter int          ADDR_W        = router_pkg::ADDR_W,
    parameter int          DATA_W        = router_pkg::DATA_W,
    parameter int          PAYLOAD_WORDS = 4,
    parameter logic [15:0] MAGIC         = router_pkg::MAGIC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              router_start_req,
    input  logic [ADDR_W-1:0] router_scr_addr,
    input  logic [ADDR_W-1:0] router_dst_addr,
    output logic              router_done,
    output logic              router_busy,
    output logic              router_req_drop,
    input  logic [DATA_W-1:0] pl_tdata,
    input  logic              pl_tvalid,
    output logic              pl_tready,
    output logic [DATA_W-1:0] aurora_tx_tdata,
    output logic              aurora_tx_tvalid,
    output logic              aurora_tx_tlast,
    input  logic              aurora_tx_tready
);

    localparam logic [7:0] LEN  = 8'(PAYLOAD_WORDS);
    localparam logic [7:0] LAST = 8'(PAYLOAD_WORDS - 1);

    tx_state_e         state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] csum_q, csum_d;

    logic              load;
    logic [DATA_W-1:0] din;
    logic              dlast;
    logic              can_load;

    axis_out_reg #(.W(DATA_W)) u_out (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .din_i      (din),
        .last_i     (dlast),
        .tready_i   (aurora_tx_tready),
        .tdata_o    (aurora_tx_tdata),
        .tvalid_o   (aurora_tx_tvalid),
        .tlast_o    (aurora_tx_tlast),
        .can_load_o (can_load)
    );

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        csum_d          = csum_q;
        load            = 1'b0;
        din             = '0;
        dlast           = 1'b0;
        pl_tready       = 1'b0;
        router_done     = 1'b0;
        router_busy     = 1'b1;
        router_req_drop = router_start_req && (state_q != ST_IDLE);
        unique case (state_q)
            ST_IDLE: begin
                router_busy = 1'b0;
                // Header is loaded on the request edge so it is on the
                // bus the following cycle; the register holds the addresses.
                if (router_start_req) begin
                    load    = 1'b1;
                    din     = build_hdr(MAGIC, LEN,
                                        router_dst_addr, router_scr_addr);
                    cnt_d   = '0;
                    csum_d  = '0;
                    state_d = ST_HDR;
                end
            end
            ST_HDR, ST_DATA: begin
                // In HDR, can_load means the header is being accepted,
                // so the first payload word can replace it directly.
                pl_tready = can_load;
                if (pl_tvalid && can_load) begin
                    load    = 1'b1;
                    din     = pl_tdata;
                    csum_d  = csum_q ^ pl_tdata;
                    cnt_d   = cnt_q + 8'd1;
                    state_d = (cnt_q == LAST) ? ST_CSUM : ST_DATA;
                end else if (can_load) begin
                    state_d = ST_DATA;
                end
            end
            ST_CSUM: begin
                // tlast in the register marks the checksum as loaded.
                if (!aurora_tx_tlast) begin
                    if (can_load) begin
                        load  = 1'b1;
                        din   = csum_q;
                        dlast = 1'b1;
                    end
                end else if (aurora_tx_tvalid && aurora_tx_tready) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                router_done = 1'b1;
                router_busy = 1'b0;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            csum_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
        end
    end

endmodule
